// File: rtl/time_set_ctrl_if.sv
// Command/status bus from the time-setting controller to the timekeeper and display.
// The controller holds set_all_times for a whole commit window; the timekeeper samples it
// on its own 100 Hz tick, so there is no valid/ready pair: a nonzero code is the "valid",
// and acceptance is guaranteed by the hold time rather than acknowledged.
interface time_set_ctrl_if;
    logic [1:0] set_all_times;
    logic [5:0] btn_time_set;
    logic [5:0] btn_min_set;
    logic       editing;
    logic [1:0] field_sel;
    logic       blink;
    logic [2:0] dbg_state;

    modport master (
        output set_all_times, btn_time_set, btn_min_set,
        output editing, field_sel, blink, dbg_state
    );
    modport slave (
        input set_all_times, btn_time_set, btn_min_set,
        input editing, field_sel, blink, dbg_state
    );
endinterface

// File: rtl/time_set_ctrl.sv
// Button-driven clock/reminder time-setting controller with timed commit commands.
// Optional hold-to-repeat on up/down is enabled by defining TIME_SET_AUTOREPEAT_EN.
module time_set_ctrl #(
    parameter int COMMIT_TICKS   = 3,
    parameter int TIMEOUT_TICKS  = 1000,
    parameter int BLINK_TICKS    = 50,
    parameter int REMIND_DEFAULT = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       power_on,
    input  logic       btn_enter,
    input  logic       btn_next,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic [5:0] cur_hour,
    input  logic [5:0] cur_minute,
    time_set_ctrl_if.master bus
);
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    localparam int BW = $clog2(BLINK_TICKS + 1);
    localparam int CW = $clog2(COMMIT_TICKS + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_TICKS - 1);
    localparam logic [BW-1:0] BL_LAST = BW'(BLINK_TICKS - 1);
    localparam logic [CW-1:0] CM_LAST = CW'(COMMIT_TICKS - 1);

    typedef enum logic [2:0] {
        ST_IDLE          = 3'd0,
        ST_EDIT_HOUR     = 3'd1,
        ST_EDIT_MIN      = 3'd2,
        ST_EDIT_REMIND   = 3'd3,
        ST_COMMIT_CLOCK  = 3'd4,
        ST_COMMIT_REMIND = 3'd5
    } state_e;

    function automatic logic is_edit(input state_e s);
        return (s == ST_EDIT_HOUR) || (s == ST_EDIT_MIN) || (s == ST_EDIT_REMIND);
    endfunction

    function automatic logic [5:0] wrap_step(input logic [5:0] v, input logic up,
                                             input logic [5:0] max);
        if (up) return (v == max) ? 6'd0 : v + 6'd1;
        else    return (v == 6'd0) ? max : v - 6'd1;
    endfunction

    // bit order: {down, up, next, enter}
    logic [3:0] meta_q, sync_q, prev_q, rise;
    assign rise = sync_q & ~prev_q;

    state_e         state_q, state_d;
    logic [5:0]     edit_hour_q, edit_hour_d, edit_min_q, edit_min_d;
    logic [5:0]     edit_remind_q, edit_remind_d, remind_hour_q, remind_hour_d;
    logic [TW-1:0]  idle_cnt_q, idle_cnt_d;
    logic [BW-1:0]  blink_cnt_q, blink_cnt_d;
    logic [CW-1:0]  commit_cnt_q, commit_cnt_d;
    logic           blink_q, blink_d;
    logic [1:0]     sat_q, sat_d, field_q, field_d;
    logic [5:0]     bts_q, bts_d, bms_q, bms_d;
    logic           editing_q, editing_d;
    logic           in_edit, rep_up, rep_dn, step_up, step_dn, field_change;

    assign in_edit = is_edit(state_q);

`ifdef TIME_SET_AUTOREPEAT_EN
    // First repeat after 50 held ticks, then every 10 ticks (counter reloads to 40).
    logic [5:0] hold_cnt_q, hold_cnt_d;
    logic       held_up, held_dn;
    assign held_up = sync_q[2] & ~sync_q[3];
    assign held_dn = sync_q[3] & ~sync_q[2];

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        rep_up     = 1'b0;
        rep_dn     = 1'b0;
        if (!in_edit || !(held_up || held_dn) || rise[2] || rise[3]) begin
            hold_cnt_d = 6'd0;
        end else if (tick) begin
            if (hold_cnt_q == 6'd49) begin
                hold_cnt_d = 6'd40;
                rep_up     = held_up;
                rep_dn     = held_dn;
            end else begin
                hold_cnt_d = hold_cnt_q + 6'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) hold_cnt_q <= 6'd0;
        else        hold_cnt_q <= hold_cnt_d;
    end
`else
    assign rep_up = 1'b0;
    assign rep_dn = 1'b0;
`endif

    assign step_up = in_edit & ((rise[2] & ~rise[3]) | rep_up);
    assign step_dn = in_edit & ((rise[3] & ~rise[2]) | rep_dn);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q        <= '0;
            sync_q        <= '0;
            prev_q        <= '0;
            state_q       <= ST_IDLE;
            edit_hour_q   <= '0;
            edit_min_q    <= '0;
            edit_remind_q <= 6'(REMIND_DEFAULT);
            remind_hour_q <= 6'(REMIND_DEFAULT);
            idle_cnt_q    <= '0;
            blink_cnt_q   <= '0;
            commit_cnt_q  <= '0;
            blink_q       <= 1'b0;
            sat_q         <= 2'b00;
            bts_q         <= '0;
            bms_q         <= '0;
            editing_q     <= 1'b0;
            field_q       <= 2'b00;
        end else begin
            meta_q        <= {btn_down, btn_up, btn_next, btn_enter};
            sync_q        <= meta_q;
            prev_q        <= sync_q;
            state_q       <= state_d;
            edit_hour_q   <= edit_hour_d;
            edit_min_q    <= edit_min_d;
            edit_remind_q <= edit_remind_d;
            remind_hour_q <= remind_hour_d;
            idle_cnt_q    <= idle_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            commit_cnt_q  <= commit_cnt_d;
            blink_q       <= blink_d;
            sat_q         <= sat_d;
            bts_q         <= bts_d;
            bms_q         <= bms_d;
            editing_q     <= editing_d;
            field_q       <= field_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        edit_hour_d   = edit_hour_q;
        edit_min_d    = edit_min_q;
        edit_remind_d = edit_remind_q;
        remind_hour_d = remind_hour_q;
        commit_cnt_d  = commit_cnt_q;
        field_change  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                commit_cnt_d = '0;
                if (rise[0] && power_on) begin
                    edit_hour_d   = cur_hour;
                    edit_min_d    = cur_minute;
                    edit_remind_d = remind_hour_q;
                    state_d       = ST_EDIT_HOUR;
                end
            end
            ST_EDIT_HOUR, ST_EDIT_MIN, ST_EDIT_REMIND: begin
                commit_cnt_d = '0;
                if (rise[0]) begin
                    if (state_q == ST_EDIT_REMIND) begin
                        remind_hour_d = edit_remind_q;
                        state_d       = ST_COMMIT_REMIND;
                    end else begin
                        state_d = ST_COMMIT_CLOCK;
                    end
                end else if (rise[1]) begin
                    field_change = 1'b1;
                    state_d = (state_q == ST_EDIT_HOUR) ? ST_EDIT_MIN :
                              (state_q == ST_EDIT_MIN)  ? ST_EDIT_REMIND : ST_EDIT_HOUR;
                end else if (step_up || step_dn) begin
                    if (state_q == ST_EDIT_HOUR)
                        edit_hour_d = wrap_step(edit_hour_q, step_up, 6'd23);
                    else if (state_q == ST_EDIT_MIN)
                        edit_min_d = wrap_step(edit_min_q, step_up, 6'd59);
                    else
                        edit_remind_d = wrap_step(edit_remind_q, step_up, 6'd23);
                end else if (tick && idle_cnt_q == TO_LAST) begin
                    edit_remind_d = remind_hour_q;
                    state_d       = ST_IDLE;
                end
            end
            ST_COMMIT_CLOCK, ST_COMMIT_REMIND: begin
                if (tick) begin
                    if (commit_cnt_q == CM_LAST) state_d = ST_IDLE;
                    else commit_cnt_d = commit_cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Power loss overrides everything, including a reminder commit in flight.
        if (!power_on) begin
            state_d       = ST_IDLE;
            remind_hour_d = remind_hour_q;
            edit_remind_d = remind_hour_q;
        end

        idle_cnt_d = idle_cnt_q;
        if (!is_edit(state_d) || !in_edit || rise[0] || rise[1] || step_up || step_dn)
            idle_cnt_d = '0;
        else if (tick)
            idle_cnt_d = idle_cnt_q + TW'(1);

        blink_d     = blink_q;
        blink_cnt_d = blink_cnt_q;
        if (!is_edit(state_d)) begin
            blink_d     = 1'b0;
            blink_cnt_d = '0;
        end else if (!in_edit || field_change) begin
            blink_d     = 1'b1;
            blink_cnt_d = '0;
        end else if (tick) begin
            if (blink_cnt_q == BL_LAST) begin
                blink_d     = ~blink_q;
                blink_cnt_d = '0;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end
    end

    // Outputs are decoded from the next state so they register on the same edge as the state.
    always_comb begin
        sat_d     = 2'b00;
        bts_d     = edit_hour_d;
        bms_d     = edit_min_d;
        editing_d = 1'b0;
        field_d   = 2'b00;
        unique case (state_d)
            ST_EDIT_HOUR:     begin editing_d = 1'b1; field_d = 2'b01; end
            ST_EDIT_MIN:      begin editing_d = 1'b1; field_d = 2'b10; end
            ST_EDIT_REMIND:   begin editing_d = 1'b1; field_d = 2'b11; end
            ST_COMMIT_CLOCK:  sat_d = 2'b01;
            ST_COMMIT_REMIND: begin sat_d = 2'b10; bts_d = remind_hour_d; end
            default: ;
        endcase
    end

    assign bus.set_all_times = sat_q;
    assign bus.btn_time_set  = bts_q;
    assign bus.btn_min_set   = bms_q;
    assign bus.editing       = editing_q;
    assign bus.field_sel     = field_q;
    assign bus.blink         = blink_q;
    assign bus.dbg_state     = state_q;
endmodule
